// File: rtl/acia_pkg.sv
// Shared types and constants for the ACIA transmit path: FSM states, command/control
// word field positions, word-length, parity and stop-length encodings.
package acia_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } tx_state_e;

  typedef enum logic [1:0] {
    STOP_ONE      = 2'd0,
    STOP_ONE_HALF = 2'd1,
    STOP_TWO      = 2'd2
  } stop_len_e;

  // data_cmd field positions
  localparam int CMD_DTR      = 0;
  localparam int CMD_TXC_LO   = 2;
  localparam int CMD_TXC_HI   = 3;
  localparam int CMD_PAR_EN   = 5;
  localparam int CMD_PMODE_LO = 6;
  localparam int CMD_PMODE_HI = 7;

  // data_ctrl field positions
  localparam int CTRL_WL_LO = 5;
  localparam int CTRL_WL_HI = 6;
  localparam int CTRL_STOP  = 7;

  localparam logic [1:0] TXC_IRQ   = 2'b01;
  localparam logic [1:0] TXC_BREAK = 2'b11;

  localparam logic [1:0] WL_8 = 2'b00;
  localparam logic [1:0] WL_7 = 2'b01;
  localparam logic [1:0] WL_6 = 2'b10;
  localparam logic [1:0] WL_5 = 2'b11;

  localparam logic [1:0] PAR_ODD   = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  // Two-stop selection shortens to 1.5 for 5N and to 1 for 8-bit with parity.
  function automatic stop_len_e stop_decode(input logic stop_sel,
                                            input logic [1:0] wl,
                                            input logic par_en);
    stop_len_e len;
    if (!stop_sel)
      len = STOP_ONE;
    else if (wl == WL_5 && !par_en)
      len = STOP_ONE_HALF;
    else if (wl == WL_8 && par_en)
      len = STOP_ONE;
    else
      len = STOP_TWO;
    return len;
  endfunction

endpackage

// File: rtl/acia_bit_timer.sv
// Counts baud ticks over one bit period (full or half length) and strobes
// bit_done on the tick that completes it; the count restarts automatically.
module acia_bit_timer #(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic enable,
  input  logic tick,
  input  logic half,
  output logic bit_done
);

  localparam int CW = (TICKS_PER_BIT > 2) ? $clog2(TICKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] last_cnt;

  assign last_cnt = half ? CW'(TICKS_PER_BIT / 2 - 1) : CW'(TICKS_PER_BIT - 1);

  always_comb begin
    cnt_next = cnt_reg;
    bit_done = 1'b0;
    if (!enable) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt_reg == last_cnt) begin
        bit_done = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

endmodule

// File: rtl/acia_tx.sv
// 6551-style serial transmitter: double-buffered holding/shift registers, frame
// FSM with optional parity, 1/1.5/2 stop bits and a break state.
module acia_tx
  import acia_pkg::*;
#(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic       clock_uc,
  input  logic       reset_uc,
  input  logic       baud_tick,
  input  logic       load,
  input  logic [7:0] data_txd,
  input  logic [7:0] data_cmd,
  input  logic [7:0] data_ctrl,
  input  logic       _cts,
  output logic       txd,
  output logic       tdre,
  output logic       busy,
  output logic       int_tx
);

  tx_state_e  state_reg, state_next;
  logic [7:0] hold_reg, hold_next;
  logic [7:0] shift_reg, shift_next;
  logic       tdre_reg, tdre_next;
  logic       txd_reg, txd_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic       par_acc_reg, par_acc_next;
  logic [1:0] wl_reg, wl_next;
  logic       par_en_reg, par_en_next;
  logic [1:0] pmode_reg, pmode_next;
  stop_len_e  stop_reg, stop_next;

  logic       bit_done;
  logic       timer_en;
  logic       timer_half;
  logic       start_ok;
  logic       start_xfer;
  logic       parity_bit;
  logic [2:0] last_idx;
  logic       stop_last;
  logic       unused_bits;

  assign unused_bits = ^{data_ctrl[4:0], data_cmd[4], data_cmd[1]};

  assign start_ok = !tdre_reg && data_cmd[CMD_DTR] && !_cts && baud_tick;

  // Word-length code 00..11 maps to last data bit index 7..4.
  assign last_idx  = 3'd7 - {1'b0, wl_reg};
  assign stop_last = (stop_reg != STOP_ONE);

  assign timer_en   = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                      (state_reg == ST_PARITY) || (state_reg == ST_STOP);
  assign timer_half = (state_reg == ST_STOP) && (bit_cnt_reg == 3'd1) &&
                      (stop_reg == STOP_ONE_HALF);

  always_comb begin
    case (pmode_reg)
      PAR_ODD:   parity_bit = ~par_acc_reg;
      PAR_EVEN:  parity_bit = par_acc_reg;
      PAR_MARK:  parity_bit = 1'b1;
      PAR_SPACE: parity_bit = 1'b0;
      default:   parity_bit = 1'b1;
    endcase
  end

  acia_bit_timer #(
    .TICKS_PER_BIT(TICKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clock_uc),
    .srst    (reset_uc),
    .enable  (timer_en),
    .tick    (baud_tick),
    .half    (timer_half),
    .bit_done(bit_done)
  );

  always_comb begin
    state_next   = state_reg;
    hold_next    = hold_reg;
    shift_next   = shift_reg;
    tdre_next    = tdre_reg;
    txd_next     = txd_reg;
    bit_cnt_next = bit_cnt_reg;
    par_acc_next = par_acc_reg;
    wl_next      = wl_reg;
    par_en_next  = par_en_reg;
    pmode_next   = pmode_reg;
    stop_next    = stop_reg;
    start_xfer   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (baud_tick && data_cmd[CMD_TXC_HI:CMD_TXC_LO] == TXC_BREAK) begin
          state_next = ST_BREAK;
          txd_next   = 1'b0;
        end else if (start_ok) begin
          start_xfer = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_next   = ST_DATA;
          txd_next     = shift_reg[0];
          par_acc_next = par_acc_reg ^ shift_reg[0];
          shift_next   = {1'b0, shift_reg[7:1]};
          bit_cnt_next = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt_reg == last_idx) begin
            bit_cnt_next = 3'd0;
            if (par_en_reg) begin
              state_next = ST_PARITY;
              txd_next   = parity_bit;
            end else begin
              state_next = ST_STOP;
              txd_next   = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            txd_next     = shift_reg[0];
            par_acc_next = par_acc_reg ^ shift_reg[0];
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_next   = ST_STOP;
          txd_next     = 1'b1;
          bit_cnt_next = 3'd0;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (bit_cnt_reg[0] == stop_last) begin
            if (start_ok)
              start_xfer = 1'b1;
            else
              state_next = ST_IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end
      ST_BREAK: begin
        if (baud_tick && data_cmd[CMD_TXC_HI:CMD_TXC_LO] != TXC_BREAK) begin
          state_next = ST_IDLE;
          txd_next   = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        txd_next   = 1'b1;
      end
    endcase

    // Frame format is frozen here so mid-frame command changes wait a frame.
    if (start_xfer) begin
      state_next   = ST_START;
      shift_next   = hold_reg;
      tdre_next    = 1'b1;
      txd_next     = 1'b0;
      bit_cnt_next = 3'd0;
      par_acc_next = 1'b0;
      wl_next      = data_ctrl[CTRL_WL_HI:CTRL_WL_LO];
      par_en_next  = data_cmd[CMD_PAR_EN];
      pmode_next   = data_cmd[CMD_PMODE_HI:CMD_PMODE_LO];
      stop_next    = stop_decode(data_ctrl[CTRL_STOP],
                                 data_ctrl[CTRL_WL_HI:CTRL_WL_LO],
                                 data_cmd[CMD_PAR_EN]);
    end

    // A load racing the start transfer wins the holding register and tdre.
    if (load) begin
      hold_next = data_txd;
      tdre_next = 1'b0;
    end
  end

  always_ff @(posedge clock_uc) begin
    if (reset_uc) begin
      state_reg   <= ST_IDLE;
      hold_reg    <= 8'h00;
      shift_reg   <= 8'h00;
      tdre_reg    <= 1'b1;
      txd_reg     <= 1'b1;
      bit_cnt_reg <= 3'd0;
      par_acc_reg <= 1'b0;
      wl_reg      <= WL_8;
      par_en_reg  <= 1'b0;
      pmode_reg   <= PAR_ODD;
      stop_reg    <= STOP_ONE;
    end else begin
      state_reg   <= state_next;
      hold_reg    <= hold_next;
      shift_reg   <= shift_next;
      tdre_reg    <= tdre_next;
      txd_reg     <= txd_next;
      bit_cnt_reg <= bit_cnt_next;
      par_acc_reg <= par_acc_next;
      wl_reg      <= wl_next;
      par_en_reg  <= par_en_next;
      pmode_reg   <= pmode_next;
      stop_reg    <= stop_next;
    end
  end

  assign txd    = txd_reg;
  assign tdre   = tdre_reg;
  assign busy   = (state_reg != ST_IDLE);
  assign int_tx = tdre_reg & data_cmd[CMD_DTR] &
                  (data_cmd[CMD_TXC_HI:CMD_TXC_LO] == TXC_IRQ);

endmodule

// File: tb/tb_acia_tx.sv
// Directed bench for acia_tx: expected txd levels, one per baud tick, are queued
// when a character is loaded and popped as each tick is applied.
module tb_acia_tx;

  logic       clock_uc = 1'b0;
  logic       reset_uc;
  logic       baud_tick;
  logic       load;
  logic [7:0] data_txd;
  logic [7:0] data_cmd;
  logic [7:0] data_ctrl;
  logic       cts_n;
  logic       txd;
  logic       tdre;
  logic       busy;
  logic       int_tx;

  int   vectors = 0;
  int   miscompares = 0;
  int   tick_no = 0;
  logic exp_q[$];

  acia_tx #(.TICKS_PER_BIT(16)) dut (
    .clock_uc (clock_uc),
    .reset_uc (reset_uc),
    .baud_tick(baud_tick),
    .load     (load),
    .data_txd (data_txd),
    .data_cmd (data_cmd),
    .data_ctrl(data_ctrl),
    ._cts     (cts_n),
    .txd      (txd),
    .tdre     (tdre),
    .busy     (busy),
    .int_tx   (int_tx)
  );

  always #5 clock_uc = ~clock_uc;

  task automatic chk1(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic tk);
    baud_tick = tk;
    @(posedge clock_uc);
    #1;
    baud_tick = 1'b0;
  endtask

  // One baud tick; with gap set, an idle clock follows and txd must not move.
  task automatic tick(input bit gap);
    logic e;
    cyc(1'b1);
    tick_no++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
    chk1($sformatf("txd@tick%0d", tick_no), txd, e);
    if (gap) begin
      cyc(1'b0);
      chk1($sformatf("txd_hold@tick%0d", tick_no), txd, e);
    end
  endtask

  task automatic run_ticks(input int n, input bit gap);
    for (int i = 0; i < n; i++) tick(gap);
  endtask

  task automatic load_char(input logic [7:0] d);
    data_txd = d;
    load = 1'b1;
    cyc(1'b0);
    load = 1'b0;
  endtask

  task automatic push_level(input logic lvl, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(lvl);
  endtask

  // Reference frame model built straight from the 6551 format rules.
  task automatic push_frame(input logic [7:0] d, input logic [7:0] ctrl, input logic [7:0] cmd);
    int   nbits;
    int   stop_ticks;
    logic ones;
    logic pb;
    nbits = 8 - int'(ctrl[6:5]);
    ones = 1'b0;
    push_level(1'b0, 16);
    for (int i = 0; i < nbits; i++) begin
      push_level(d[i], 16);
      ones = ones ^ d[i];
    end
    if (cmd[5]) begin
      case (cmd[7:6])
        2'b00:   pb = ~ones;
        2'b01:   pb = ones;
        2'b10:   pb = 1'b1;
        default: pb = 1'b0;
      endcase
      push_level(pb, 16);
    end
    if (!ctrl[7])                    stop_ticks = 16;
    else if (nbits == 5 && !cmd[5])  stop_ticks = 24;
    else if (nbits == 8 && cmd[5])   stop_ticks = 16;
    else                             stop_ticks = 32;
    push_level(1'b1, stop_ticks);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] ctrl, input logic [7:0] cmd,
                      input int total, input bit gap);
    data_ctrl = ctrl;
    data_cmd = cmd;
    load_char(d);
    chk1("tdre_after_load", tdre, 1'b0);
    push_frame(d, ctrl, cmd);
    tick(gap);
    chk1("tdre_after_start", tdre, 1'b1);
    chk1("busy_in_frame", busy, 1'b1);
    run_ticks(total - 1, gap);
    chk1("busy_end_of_stop", busy, 1'b1);
    tick(gap);
    chk1("busy_after_frame", busy, 1'b0);
  endtask

  initial begin
    reset_uc = 1'b1;
    baud_tick = 1'b0;
    load = 1'b0;
    data_txd = 8'h00;
    data_cmd = 8'h00;
    data_ctrl = 8'h00;
    cts_n = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    chk1("reset_txd", txd, 1'b1);
    chk1("reset_tdre", tdre, 1'b1);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_int_tx", int_tx, 1'b0);
    reset_uc = 1'b0;
    cts_n = 1'b0;
    cyc(1'b0);

    // 8N1, 7E1, 5N1.5 (consecutive ticks), 7O2, 8-bit mark parity with one stop
    send(8'h55, 8'h00, 8'h01, 160, 1'b1);
    send(8'h41, 8'h20, 8'h61, 160, 1'b1);
    send(8'h1F, 8'hE0, 8'h01, 120, 1'b0);
    send(8'h03, 8'hA0, 8'h21, 176, 1'b1);
    send(8'h80, 8'h80, 8'hA1, 176, 1'b1);

    // Back-to-back frames with the TX interrupt enabled
    data_ctrl = 8'h00;
    data_cmd = 8'h05;
    cyc(1'b0);
    chk1("int_tx_idle", int_tx, 1'b1);
    load_char(8'hA5);
    chk1("int_tx_after_load", int_tx, 1'b0);
    push_frame(8'hA5, 8'h00, 8'h05);
    push_frame(8'h3C, 8'h00, 8'h05);
    tick(1'b1);
    chk1("int_tx_first_start", int_tx, 1'b1);
    run_ticks(49, 1'b1);
    load_char(8'h3C);
    chk1("int_tx_second_load", int_tx, 1'b0);
    chk1("tdre_second_load", tdre, 1'b0);
    run_ticks(110, 1'b1);
    chk1("int_tx_before_second", int_tx, 1'b0);
    chk1("busy_before_second", busy, 1'b1);
    tick(1'b1);
    chk1("tdre_second_start", tdre, 1'b1);
    chk1("int_tx_second_start", int_tx, 1'b1);
    run_ticks(163, 1'b1);
    chk1("busy_after_b2b", busy, 1'b0);

    // CTS gating
    data_cmd = 8'h01;
    cts_n = 1'b1;
    load_char(8'h00);
    run_ticks(20, 1'b1);
    chk1("tdre_cts_blocked", tdre, 1'b0);
    chk1("busy_cts_blocked", busy, 1'b0);
    cts_n = 1'b0;
    push_frame(8'h00, 8'h00, 8'h01);
    run_ticks(162, 1'b1);
    chk1("tdre_after_cts", tdre, 1'b1);
    chk1("busy_after_cts", busy, 1'b0);

    // Break
    data_cmd = 8'h0D;
    push_level(1'b0, 10);
    run_ticks(10, 1'b1);
    chk1("busy_break", busy, 1'b1);
    chk1("int_tx_break", int_tx, 1'b0);
    data_cmd = 8'h01;
    run_ticks(3, 1'b1);
    chk1("busy_after_break", busy, 1'b0);

    // Reset in the middle of data bit 3, with a character pending
    load_char(8'h00);
    push_frame(8'h00, 8'h00, 8'h01);
    run_ticks(70, 1'b1);
    chk1("txd_mid_bit3", txd, 1'b0);
    load_char(8'h77);
    reset_uc = 1'b1;
    cyc(1'b0);
    chk1("rst_mid_txd", txd, 1'b1);
    chk1("rst_mid_tdre", tdre, 1'b1);
    chk1("rst_mid_busy", busy, 1'b0);
    reset_uc = 1'b0;
    exp_q.delete();
    run_ticks(20, 1'b1);
    chk1("busy_after_rst", busy, 1'b0);
    chk1("tdre_after_rst", tdre, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
